// File: rtl/ckp_wheel_gen.sv
// Crankshaft wheel emulator: produces a TEETH-minus-GAP toothed waveform with a
// programmable tooth period, plus per-tooth and per-revolution strobes.
module ckp_wheel_gen #(
  parameter int unsigned TEETH = 60,
  parameter int unsigned GAP   = 2,
  parameter int unsigned PW    = 24,
  parameter int unsigned TW    = 6,
  parameter int unsigned PMIN  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [PW-1:0] period,
  output logic          cap,
  output logic [TW-1:0] tooth_num,
  output logic          tooth_stb,
  output logic          rev_stb,
  output logic          running
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [TW-1:0] LAST_TOOTH = TW'(TEETH - 1);
  localparam logic [TW-1:0] FIRST_GAP  = TW'(TEETH - GAP);
  localparam logic [PW-1:0] PMIN_V     = PW'(PMIN);

  state_t        r_state, w_state;
  logic [PW-1:0] r_p, w_p;
  logic [PW-1:0] r_phase, w_phase;
  logic [TW-1:0] r_tooth, w_tooth;
  logic          r_cap, w_cap;
  logic          r_tstb, w_tstb;
  logic          r_rstb, w_rstb;
  logic          r_run, w_run;

  logic          w_ok;
  logic          w_bound;
  logic [TW-1:0] w_tnext;
  logic [PW-1:0] w_ph1;

  assign w_ok    = (period >= PMIN_V);
  assign w_bound = (r_phase == r_p - PW'(1));
  assign w_tnext = (r_tooth == LAST_TOOTH) ? '0 : r_tooth + TW'(1);
  assign w_ph1   = r_phase + PW'(1);

  // Defaults describe the idle wheel; only RUN paths override them.
  always_comb begin
    w_state = r_state;
    w_p     = r_p;
    w_phase = '0;
    w_tooth = '0;
    w_cap   = 1'b0;
    w_tstb  = 1'b0;
    w_rstb  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ena && w_ok) begin
          w_state = S_RUN;
          w_p     = period;
          w_cap   = 1'b1;
          w_tstb  = 1'b1;
          w_rstb  = 1'b1;
        end
      end
      S_RUN: begin
        if (!ena) begin
          w_state = S_IDLE;
        end else if (w_bound) begin
          // New period is only accepted here, so a tooth is never stretched or cut.
          if (!w_ok) begin
            w_state = S_IDLE;
          end else begin
            w_p     = period;
            w_tooth = w_tnext;
            w_cap   = (w_tnext < FIRST_GAP);
            w_tstb  = 1'b1;
            w_rstb  = (w_tnext == '0);
          end
        end else begin
          w_phase = w_ph1;
          w_tooth = r_tooth;
          w_cap   = (r_tooth < FIRST_GAP) && (w_ph1 < (r_p >> 1));
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_run = (w_state == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_p     <= '0;
      r_phase <= '0;
      r_tooth <= '0;
      r_cap   <= 1'b0;
      r_tstb  <= 1'b0;
      r_rstb  <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_p     <= w_p;
      r_phase <= w_phase;
      r_tooth <= w_tooth;
      r_cap   <= w_cap;
      r_tstb  <= w_tstb;
      r_rstb  <= w_rstb;
      r_run   <= w_run;
    end
  end

  assign cap       = r_cap;
  assign tooth_num = r_tooth;
  assign tooth_stb = r_tstb;
  assign rev_stb   = r_rstb;
  assign running   = r_run;

endmodule

// File: tb/tb_ckp_wheel_gen.sv
// Directed bench for ckp_wheel_gen: wheel shape, period updates, aborts, reset.
module tb_ckp_wheel_gen;
  localparam int PW = 24;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic [PW-1:0] period = '0;
  logic          cap;
  logic [TW-1:0] tooth_num;
  logic          tooth_stb, rev_stb, running;

  int n_tests = 0;
  int n_fail  = 0;

  ckp_wheel_gen #(.TEETH(60), .GAP(2), .PW(PW), .TW(TW), .PMIN(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .period(period), .cap(cap),
    .tooth_num(tooth_num), .tooth_stb(tooth_stb), .rev_stb(rev_stb), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int err;
    int zrun;
    int k, ph;

    // reset state
    repeat (3) tick();
    chk("rst_outs", {27'd0, cap, tooth_stb, rev_stb, running, |tooth_num}, 32'd0);
    rst = 1'b1;
    period = 24'd8;
    tick();
    chk("idle_no_ena", running, 0);

    // period 8, one full revolution
    ena = 1'b1;
    tick();
    chk("start_run", running, 1);
    chk("start_rev", rev_stb, 1);
    err = 0;
    for (int i = 0; i < 480; i++) begin
      if (i > 0) tick();
      k = i / 8; ph = i % 8;
      if (cap !== ((k < 58) && (ph < 4))) err++;
      if (tooth_num !== TW'(k)) err++;
      if (tooth_stb !== (ph == 0)) err++;
      if (rev_stb !== (i == 0)) err++;
      if (i == 459) chk("t57_last_hi", cap, 1);
      if (i == 460) chk("t57_first_lo", cap, 0);
      if (i == 464) chk("t58_missing", cap, 0);
    end
    chk("p8_wave_errs", err, 0);
    tick();
    chk("p8_wrap_rev", rev_stb, 1);
    chk("p8_wrap_tooth", tooth_num, 0);
    chk("p8_wrap_cap", cap, 1);

    // period 8 -> 12 in the middle of tooth 10
    repeat (83) tick();
    chk("t10_reached", tooth_num, 10);
    period = 24'd12;
    repeat (4) tick();
    chk("t10_ph7_tooth", tooth_num, 10);
    chk("t10_ph7_cap", cap, 0);
    tick();
    chk("t11_stb", tooth_stb, 1);
    err = 0;
    for (int j = 0; j < 12; j++) begin
      if (j > 0) tick();
      if (cap !== (j < 6)) err++;
      if (tooth_num !== TW'(11)) err++;
      if (tooth_stb !== (j == 0)) err++;
    end
    chk("p12_tooth_errs", err, 0);
    tick();
    chk("t12_tooth", tooth_num, 12);
    chk("t12_stb", tooth_stb, 1);

    // period below PMIN at a boundary stops the wheel without a strobe
    period = 24'd2;
    repeat (11) tick();
    chk("lowp_still_run", running, 1);
    tick();
    chk("lowp_idle", running, 0);
    chk("lowp_no_stb", tooth_stb, 0);
    chk("lowp_cap", cap, 0);
    chk("lowp_tooth", tooth_num, 0);
    period = 24'd3;
    err = 0;
    repeat (5) begin
      tick();
      if (running !== 1'b0 || cap !== 1'b0) err++;
    end
    chk("p3_stays_idle", err, 0);

    // PMIN itself is accepted
    period = 24'd4;
    tick();
    chk("p4_run", running, 1);
    chk("p4_rev", rev_stb, 1);
    period = 24'd7;
    tick();
    chk("p4_ph1_cap", cap, 1);
    tick();
    chk("p4_ph2_cap", cap, 0);
    tick();
    tick();
    chk("p7_t1_stb", tooth_stb, 1);
    chk("p7_t1_tooth", tooth_num, 1);

    // period 7: 3 high / 4 low, gap low run of 18
    err = 0; zrun = 0;
    for (int c = 0; c < 413; c++) begin
      if (c > 0) tick();
      k = 1 + c / 7; ph = c % 7;
      if (cap !== ((k < 58) && (ph < 3))) err++;
      if (tooth_num !== TW'(k)) err++;
      if (cap) zrun = 0; else zrun++;
    end
    chk("p7_wave_errs", err, 0);
    chk("p7_gap_low", zrun, 18);
    tick();
    chk("p7_wrap_rev", rev_stb, 1);
    chk("p7_wrap_cap", cap, 1);

    // ena drop at tooth 30 phase 2
    repeat (212) tick();
    chk("t30_reached", tooth_num, 30);
    ena = 1'b0;
    tick();
    chk("abort_cap", cap, 0);
    chk("abort_tooth", tooth_num, 0);
    chk("abort_run", running, 0);
    ena = 1'b1;
    tick();
    chk("reen_run", running, 1);
    chk("reen_rev", rev_stb, 1);
    chk("reen_tooth", tooth_num, 0);

    // ena drop coinciding with a boundary
    repeat (6) tick();
    ena = 1'b0;
    tick();
    chk("abort_bnd_run", running, 0);
    chk("abort_bnd_stb", tooth_stb, 0);
    ena = 1'b1;
    tick();
    chk("reen2_run", running, 1);

    // async reset mid-cycle at tooth 45 phase 5
    repeat (320) tick();
    chk("t45_reached", tooth_num, 45);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_outs", {27'd0, cap, tooth_stb, rev_stb, running, |tooth_num}, 32'd0);
    tick();
    chk("rst_held_idle", running, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_run", running, 1);
    chk("post_rst_rev", rev_stb, 1);
    chk("post_rst_tooth", tooth_num, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
